cla_seq_adder64: RTL and testbench

Multi-cycle 64-bit adder controller that time-shares one 16-bit carry-lookahead slice across four consecutive cycles. It sequences operand slices through the slice and propagates the inter-slice carry in a register. It assembles the 64-bit result and returns it over a valid/ready handshake. It sits beside the full 64-bit CLA as the area-reduced alternative for non-critical add paths.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_adder_16bit.sv | 45 ++++
 rtl/cla_seq_adder64.sv | 112 +++++++++++
 tb/tb_cla_seq_adder64.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, state encoding and 4-bit carry generator for the sequential CLA adder
package cla_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int SLICE_DEF = 16;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
    localparam int IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lookahead carries into bits 0..3 of a 4-bit group.
    function automatic logic [3:0] cla4_carries(input logic [3:0] p, input logic [3:0] g, input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

endpackage

// File: rtl/cla_adder_16bit.sv
// rtl/cla_adder_16bit.sv - slice-wide carry-lookahead adder built from 4-bit groups
module cla_adder_16bit
    import cla_pkg::*;
#(
    parameter int W = SLICE_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    localparam int NG = W / 4;

    logic [W-1:0]  p;
    logic [W-1:0]  g;
    logic [W-1:0]  c;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gp = '0;
        gg = '0;
        gc = '0;
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            c[4*j +: 4] = cla4_carries(p[4*j +: 4], g[4*j +: 4], gc[j]);
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
    end

    assign s    = p ^ c;
    assign cout = gc[NG];

endmodule

// File: rtl/cla_seq_adder64.sv
// rtl/cla_seq_adder64.sv - multi-cycle adder sharing one CLA slice across NSLICE cycles
module cla_seq_adder64
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             c_sl;

    assign a_sl = a_q[idx*SLICE +: SLICE];
    assign b_sl = b_q[idx*SLICE +: SLICE];

    cla_adder_16bit #(.W(SLICE)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (c_sl)
    );

    // in_ready is a flop so it stays low throughout reset and only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry      <= cin;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[idx*SLICE +: SLICE] <= s_sl;
                    carry <= c_sl;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry;
    assign overflow  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder64.sv
// tb/tb_cla_seq_adder64.sv - directed and random self-checking bench for cla_seq_adder64
module tb_cla_seq_adder64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;
    logic        busy;

    int checks;
    int failures;

    cla_seq_adder64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for in_ready at a falling edge, then presents operands for one cycle.
    task automatic do_accept(input logic [63:0] av, input logic [63:0] bv, input logic cv);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts falling edges from acceptance until out_valid (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, overflow} !== 5'b0 || sum !== 64'h0) begin
            failures++;
            $display("FAIL reset_values: rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h required all 0",
                     in_ready, out_valid, busy, cout, overflow, sum);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_wrap_cout();
        int n;
        do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        wait_valid(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL latency: cycles=%0d required 4", n);
        end
        checks++;
        if (sum !== 64'h0 || cout !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_result: sum=%h cout=%b ovf=%b required 0 1 0", sum, cout, overflow);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_handshake: vld=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_hold_and_ignore();
        int n;
        do_accept(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = 1'b1;
            a = 64'h1234_5678_9ABC_DEF0;
            b = 64'h0FED_CBA9_8765_4321;
            cin = 1'b1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL run_in_ready: in_ready=%b required 0", in_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL ovf_latency: cycles=%0d required 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sum !== 64'h8000_0000_0000_0000 || cout !== 1'b0 || overflow !== 1'b1
                || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: sum=%h cout=%b ovf=%b vld=%b rdy=%b required 8000000000000000 0 1 1 0",
                         k, sum, cout, overflow, out_valid, in_ready);
            end
            if (k < 3) @(negedge clk);
        end
        handshake();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_capture: busy=%b rdy=%b required 0 1", busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL still_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_carry_boundaries();
        logic [63:0] av [3];
        logic [63:0] ev [3];
        int n;
        av[0] = 64'h0000_0000_0000_FFFF; ev[0] = 64'h0000_0000_0001_0000;
        av[1] = 64'h0000_0000_FFFF_FFFF; ev[1] = 64'h0000_0001_0000_0000;
        av[2] = 64'h0000_FFFF_FFFF_FFFF; ev[2] = 64'h0001_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            do_accept(av[i], 64'h0, 1'b1);
            wait_valid(n);
            checks++;
            if (n != 4 || sum !== ev[i] || cout !== 1'b0 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL boundary_%0d: cycles=%0d sum=%h cout=%b ovf=%b required 4 %h 0 0",
                         i, n, sum, cout, overflow, ev[i]);
            end
            handshake();
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout, overflow} !== 5'b0 || sum !== 64'h0) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h required all 0",
                     in_ready, out_valid, busy, cout, overflow, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_accept(64'd5, 64'd7, 1'b0);
        wait_valid(n);
        checks++;
        if (n != 4 || sum !== 64'd12 || cout !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fresh_add: cycles=%0d sum=%h cout=%b ovf=%b required 4 c 0 0", n, sum, cout, overflow);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [63:0] av;
        logic [63:0] bv;
        logic        cv;
        logic [64:0] ref_sum;
        logic        ref_ovf;
        logic        v;
        logic        r;
        logic        seen;
        logic        done;
        int          n;
        for (int i = 0; i < 1000; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            cv = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, av} + {1'b0, bv} + {64'h0, cv};
            ref_ovf = (av[63] == bv[63]) && (ref_sum[63] != av[63]);
            do_accept(av, bv, cv);
            seen = 1'b0;
            done = 1'b0;
            n = 0;
            while (!done && n < 100) begin
                v = out_valid;
                r = 1'($urandom_range(0, 1));
                if (v && !seen) begin
                    seen = 1'b1;
                    checks++;
                    if (sum !== ref_sum[63:0] || cout !== ref_sum[64] || overflow !== ref_ovf) begin
                        failures++;
                        $display("FAIL rand_%0d: sum=%h cout=%b ovf=%b required %h %b %b",
                                 i, sum, cout, overflow, ref_sum[63:0], ref_sum[64], ref_ovf);
                    end
                end
                out_ready = r;
                @(negedge clk);
                n++;
                if (v && r) done = 1'b1;
            end
            out_ready = 1'b0;
            checks++;
            if (!done) begin
                failures++;
                $display("FAIL rand_timeout_%0d: handshake=%b required 1", i, done);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_wrap_cout();
        test_hold_and_ignore();
        test_carry_boundaries();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
